// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor (a - b - borrow_in), LSB first, one bit per clock.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds an `op` input selecting add (1) or subtract (0).
module serial_subtractor_nbit #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic                 op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 borrow_out,
  output logic                 overflow
);

  localparam int unsigned CNT_W = $clog2(BIT_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept_c;
  logic                 last_c;

  logic [BIT_WIDTH-1:0] a_sr;
  logic [BIT_WIDTH-1:0] b_sr;
  logic [BIT_WIDTH-1:0] work;
  logic [CNT_W-1:0]     cnt;
  logic                 br;
  logic                 a_msb;
  logic                 b_msb;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic                 op_q;
`endif

  logic                 a_bit_c;
  logic                 b_bit_c;
  logic                 d_c;
  logic                 br_next_c;
  logic                 ovf_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is honoured in IDLE and DONE only
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-bit full subtractor (or adder), overflow judged from latched operand MSBs
  always_comb begin
    a_bit_c   = a_sr[0];
    b_bit_c   = b_sr[0];
    d_c       = a_bit_c ^ b_bit_c ^ br;
    br_next_c = (~a_bit_c & b_bit_c) | (~(a_bit_c ^ b_bit_c) & br);
    ovf_c     = (a_msb ^ b_msb) & (d_c ^ a_msb);
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (op_q) begin
      br_next_c = (a_bit_c & b_bit_c) | ((a_bit_c ^ b_bit_c) & br);
      ovf_c     = ~(a_msb ^ b_msb) & (d_c ^ a_msb);
    end
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      work       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_q       <= 1'b0;
`endif
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (accept_c) begin
        a_sr  <= a;
        b_sr  <= b;
        br    <= borrow_in;
        cnt   <= '0;
        a_msb <= a[BIT_WIDTH-1];
        b_msb <= b[BIT_WIDTH-1];
`ifdef SERIAL_SUB_ADD_MODE_EN
        op_q  <= op;
`endif
      end else if (state_q == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br   <= br_next_c;
        work <= {d_c, work[BIT_WIDTH-1:1]};
        cnt  <= cnt + CNT_W'(1);
      end
      // Results update only on the transition into DONE
      if (last_c) begin
        diff       <= {d_c, work[BIT_WIDTH-1:1]};
        borrow_out <= br_next_c;
        overflow   <= ovf_c;
      end
      busy <= (state_d == SHIFT);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit; exercises add mode when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor_nbit;

  localparam int W     = 8;
  localparam int LIMIT = 4 * W + 8;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         op;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op        (op),
`endif
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  // Reference: wide unsigned arithmetic for diff/borrow, signed ints for overflow
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bin, input logic opv);
    exp_t       e;
    logic [W:0] full;
    int         sa, sb, r;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (opv) begin
      full = {1'b0, av} + {1'b0, bv} + (W+1)'(bin);
      r    = sa + sb + int'(bin);
    end else begin
      full = {1'b0, av} - {1'b0, bv} - (W+1)'(bin);
      r    = sa - sb - int'(bin);
    end
    e.diff = full[W-1:0];
    e.bo   = full[W];
    e.ov   = (r < SMIN) || (r > SMAX);
    return e;
  endfunction

  // Drive one start pulse at a negedge and push its expected result; scrambles operands afterwards
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bin, input logic opv);
    a         = av;
    b         = bv;
    borrow_in = bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op        = opv;
`endif
    start     = 1'b1;
    sb_q.push_back(model(av, bv, bin, opv));
    @(negedge clk);
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
    op        = 1'($urandom);
`endif
  endtask

  // Bounded wait for done; cyc counts cycles since the accepting edge
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h bo=%b ov=%b want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   busy_cyc;
    bit   bad_done;
    issue(W'(100), W'(37), 1'b0, 1'b0);
    busy_cyc = 0;
    bad_done = 0;
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done !== 1'b0) bad_done = 1;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_vec++;
    if (busy_cyc != W || bad_done) begin
      n_bad++;
      $display("FAIL basic_busy got %0d busy cycles (early done=%b) want %0d", busy_cyc, bad_done, W);
    end
    n_vec++;
    if ({busy, done} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_done_cycle got busy=%b done=%b want 0 1 at k+%0d", busy, done, W + 1);
    end
    n_vec++;
    if ({diff, borrow_out, overflow} !== e || e.diff !== W'(63)) begin
      n_bad++;
      $display("FAIL basic_result got diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
               diff, borrow_out, overflow, e.diff, e.bo, e.ov);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || {diff, borrow_out, overflow} !== e) begin
      n_bad++;
      $display("FAIL basic_hold got done=%b diff=%h bo=%b ov=%b want done=0 diff=%h",
               done, diff, borrow_out, overflow, e.diff);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta[3] = '{W'(8'h00), W'(8'h80), W'(8'h7F)};
    logic [W-1:0] tb[3] = '{W'(8'h01), W'(8'h01), W'(8'hFF)};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] av, bv;
    logic         bin;
    exp_t         e;
    int           cyc;
    bit           ok;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) begin
        av = ta[i]; bv = tb[i]; bin = tc[i];
      end else begin
        av = W'($urandom); bv = W'($urandom); bin = 1'($urandom);
      end
      issue(av, bv, bin, 1'b0);
      wait_done(cyc, ok);
      e = sb_q.pop_front();
      n_vec++;
      if (!ok || cyc != W + 1) begin
        n_bad++;
        $display("FAIL vec%0d_latency got %0d cycles (done seen=%b) want %0d", i, cyc, ok, W + 1);
      end
      n_vec++;
      if ({diff, borrow_out, overflow} !== e) begin
        n_bad++;
        $display("FAIL vec%0d_result a=%h b=%h bin=%b got diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
                 i, av, bv, bin, diff, borrow_out, overflow, e.diff, e.bo, e.ov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_abort();
    exp_t e;
    int   cyc;
    bit   ok;
    int   n_done;
    issue(W'(8'h80), W'(8'h01), 1'b0, 1'b0);
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || {diff, borrow_out, overflow} !== e) begin
      n_bad++;
      $display("FAIL abort_setup got done=%b diff=%h ov=%b want diff=%h ov=%b",
               ok, diff, overflow, e.diff, e.ov);
    end
    @(negedge clk);
    issue(W'(8'h55), W'(8'h0F), 1'b0, 1'b0);
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      n_bad++;
      $display("FAIL abort_clear got busy=%b done=%b diff=%h bo=%b ov=%b want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    n_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done === 1'b1 || busy === 1'b1) n_done++;
      @(negedge clk);
    end
    n_vec++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL abort_no_done got %0d busy/done cycles want 0", n_done);
    end
    issue(W'(5), W'(3), 1'b0, 1'b0);
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || {diff, borrow_out, overflow} !== e || diff !== W'(2)) begin
      n_bad++;
      $display("FAIL abort_restart got done=%b diff=%h want diff=%h", ok, diff, e.diff);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int   cyc;
    bit   ok;
    int   n_done;
    issue(W'(200), W'(50), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a         = W'(1);
    b         = W'(2);
    borrow_in = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_vec++;
    if (!ok || {diff, borrow_out, overflow} !== e) begin
      n_bad++;
      $display("FAIL ignore_result got done=%b diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
               ok, diff, borrow_out, overflow, e.diff, e.bo, e.ov);
    end
    @(negedge clk);
    n_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done === 1'b1 || busy === 1'b1) n_done++;
      @(negedge clk);
    end
    n_vec++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL ignore_no_queue got %0d busy/done cycles want 0", n_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   ok;
    issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc, ok);
      e = sb_q.pop_front();
      n_vec++;
      if (!ok || cyc != W + 1 || {diff, borrow_out, overflow} !== e) begin
        n_bad++;
        $display("FAIL b2b%0d got %0d cycles diff=%h bo=%b ov=%b want %0d cycles diff=%h bo=%b ov=%b",
                 i, cyc, diff, borrow_out, overflow, W + 1, e.diff, e.bo, e.ov);
      end
      if (i < 3) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
  task automatic test_add_mode();
    exp_t         e;
    int           cyc;
    bit           ok;
    logic [W-1:0] av, bv;
    logic         bin, opv;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        av = W'(8'hFF); bv = W'(8'h01); bin = 1'b0; opv = 1'b1;
      end else begin
        av = W'($urandom); bv = W'($urandom); bin = 1'($urandom); opv = 1'(i);
      end
      issue(av, bv, bin, opv);
      wait_done(cyc, ok);
      e = sb_q.pop_front();
      n_vec++;
      if (!ok || {diff, borrow_out, overflow} !== e) begin
        n_bad++;
        $display("FAIL add%0d op=%b a=%h b=%h c=%b got diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
                 i, opv, av, bv, bin, diff, borrow_out, overflow, e.diff, e.bo, e.ov);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op        = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_rst_abort();
    test_start_ignored();
    test_back_to_back();
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Bit-serial N-bit subtractor computing `a - b - borrow_in`, LSB first, one bit per clock. It is the inverse-direction companion to the team's parallel ripple-carry adder and is used where area matters more than latency. Operands are captured on a `start` handshake. Results and flags are held stable between operations, and completion is signalled by a one-cycle `done` pulse.

## Interface
- `BIT_WIDTH`, default 8: operand/result width, must be ≥ 2.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; operands are sampled when accepted.
- `a`  in  BIT_WIDTH  minuend.
- `b`  in  BIT_WIDTH  subtrahend.
- `borrow_in`  in  1  initial borrow.
- `busy`  out  1  high while a subtraction is in progress.
- `done`  out  1  one-cycle completion pulse.
- `diff`  out  BIT_WIDTH  result, held until the next completion.
- `borrow_out`  out  1  final unsigned borrow, held.
- `overflow`  out  1  two's-complement overflow, held.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start` = 1 latches `a`, `b` into shift registers and `borrow_in` into the borrow flop.
  - Bit counter clears to 0.
  - Next state is SHIFT.
- SHIFT, one bit per cycle:
  - Bit i: `d = a_i ^ b_i ^ br`.
  - Borrow update: `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - `d` shifts in at the MSB of the working register.
  - Operand registers shift right.
  - Counter increments. After the cycle processing bit BIT_WIDTH-1, next state is DONE.
- DONE, one cycle:
  - Entry into DONE loads the working register into `diff`.
  - `borrow_out` = final `br`.
  - `overflow` = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs.
  - `done` = 1.
  - `start` = 1 in DONE is accepted exactly as in IDLE (back-to-back). Otherwise next state is IDLE.
- `start` while in SHIFT is ignored; no queueing.
- `diff`, `borrow_out`, `overflow` change only at entry to DONE, and remain stable while `busy`.
- Counter width is clog2(BIT_WIDTH)+1 and does not wrap during an operation.

## Timing
- All outputs reset to 0; state resets to IDLE.
- `rst` has priority over `start` and over all state transitions.
- `rst` mid-SHIFT aborts the operation. No `done` is issued, and held results clear to 0.
- `start` is sampled at edge k. `busy` is high for cycles k+1 … k+BIT_WIDTH.
- `done` and the new results are visible in cycle k+BIT_WIDTH+1.
- Latency start→done is BIT_WIDTH+1 clocks. Throughput is one result per BIT_WIDTH+1 clocks with back-to-back `start`.
- `busy` = (state == SHIFT). `done` = (state == DONE).
- Operand and `borrow_in` changes after the accepting edge have no effect.

## Configuration
- `SERIAL_SUB_ADD_MODE_EN` defined:
  - Adds input `op` (1 bit), sampled with the operands. `op` = 0 subtracts; `op` = 1 adds.
  - In add mode, `borrow_in` acts as carry-in.
  - Bit i: `d = a_i ^ b_i ^ c`.
  - Carry update: `c' = (a_i & b_i) | ((a_i ^ b_i) & c)`.
  - `borrow_out` reports the final carry.
  - `overflow` = (a_msb == b_msb) && (diff_msb != a_msb).
- Undefined: port `op` is absent and the block always subtracts.

## Test plan
- BIT_WIDTH=8, a=100, b=37, borrow_in=0, start at edge k:
  - `busy` high for 8 cycles.
  - `done` pulses in cycle k+9 with diff=63, borrow_out=0, overflow=0.
- a=0x00, b=0x01, borrow_in=0 → diff=0xFF, borrow_out=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, overflow=1, borrow_out=0.
- a=0x7F, b=0xFF, borrow_in=1 → diff=0x7F, borrow_out=1, overflow=0.
- Reset and `start` handling:
  - `rst` asserted at SHIFT cycle 4 → no `done`, all outputs 0 next cycle, FSM returns to IDLE.
  - Re-`start` with a=5, b=3 then produces diff=2.
  - `start` pulsed while `busy` with different operands → ignored; the original result is delivered.
- Add mode (`SERIAL_SUB_ADD_MODE_EN` defined, op=1): a=0xFF, b=0x01 → diff=0x00, borrow_out=1, overflow=0.
